// File: rtl/mt_arb_pkg.sv
// Shared types and constants for the MouseTrap per-output-port wormhole arbiter.
package mt_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } arb_state_e;

    function automatic int grant_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam arb_state_e RST_STATE   = IDLE;
    localparam logic       RST_PKT_EN  = 1'b0;
    localparam logic       RST_BUSY    = 1'b0;
    localparam logic       RST_WD_ABRT = 1'b0;
    localparam int         RST_RR_PTR  = 0;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap.
module rr_picker
    import mt_arb_pkg::*;
#(
    parameter int N = 4
) (
    input  logic [N-1:0]              req_i,
    input  logic [grant_idx_w(N)-1:0] ptr_i,
    output logic [N-1:0]              onehot_o,
    output logic [grant_idx_w(N)-1:0] idx_o,
    output logic                      any_req_o
);

    localparam int IW = grant_idx_w(N);

    logic [N-1:0]  rot;
    logic [IW-1:0] off;
    logic [IW:0]   sum;

    // Rotate so the pointer position lands at bit 0, then take the lowest set bit.
    always_comb begin
        any_req_o = |req_i;
        rot       = N'(({req_i, req_i} >> ptr_i));
        off       = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) off = IW'(k);
        end
        sum = {1'b0, ptr_i} + {1'b0, off};
        if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
        idx_o    = sum[IW-1:0];
        onehot_o = any_req_o ? (N'(1) << idx_o) : '0;
    end

endmodule

// File: rtl/packet_output_arbiter.sv
// Wormhole output-port arbiter: grants on head, holds until tail, then round-robin release.
// Optional idle watchdog compiled in with PKT_ARB_WATCHDOG_EN.
module packet_output_arbiter
    import mt_arb_pkg::*;
#(
    parameter int NUM_INPORTS = 4,
    parameter int WD_CYCLES   = 64
) (
    input  logic                                clk_i,
    input  logic                                rst_n_i,
    input  logic [NUM_INPORTS-1:0]              head_req_i,
    input  logic                                out_ready_i,
    input  logic                                flit_pass_i,
    input  logic                                tail_pass_i,
    output logic [NUM_INPORTS-1:0]              grant_o,
    output logic [grant_idx_w(NUM_INPORTS)-1:0] grant_id_o,
    output logic                                packet_enable_o,
    output logic                                busy_o,
    output logic                                wd_abort_o,
    output arb_state_e                          dbg_state_o,
    output logic [grant_idx_w(NUM_INPORTS)-1:0] dbg_rr_ptr_o
);

    localparam int IW = grant_idx_w(NUM_INPORTS);

    arb_state_e             state_q, state_d;
    logic [NUM_INPORTS-1:0] grant_q, grant_d;
    logic [IW-1:0]          grant_id_q, grant_id_d;
    logic                   pkt_en_q, pkt_en_d;
    logic                   busy_q, busy_d;
    logic [IW-1:0]          rr_ptr_q, rr_ptr_d;

    logic [NUM_INPORTS-1:0] win_oh;
    logic [IW-1:0]          win_idx;
    logic                   any_req;
    logic                   wd_fire;

    rr_picker #(.N(NUM_INPORTS)) u_picker (
        .req_i     (head_req_i),
        .ptr_i     (rr_ptr_q),
        .onehot_o  (win_oh),
        .idx_o     (win_idx),
        .any_req_o (any_req)
    );

`ifdef PKT_ARB_WATCHDOG_EN
    localparam int WDW = $clog2(WD_CYCLES + 1);

    logic [WDW-1:0] wd_cnt_q, wd_cnt_d;
    logic           wd_abort_q, wd_abort_d;

    // Counts consecutive flit-less BUSY cycles; any flit or leaving BUSY clears it.
    always_comb begin
        wd_cnt_d = '0;
        wd_fire  = 1'b0;
        if (state_q == BUSY && !flit_pass_i) begin
            if (wd_cnt_q == WDW'(WD_CYCLES - 1)) wd_fire = 1'b1;
            else                                 wd_cnt_d = wd_cnt_q + 1'b1;
        end
        wd_abort_d = wd_fire;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wd_cnt_q   <= '0;
            wd_abort_q <= RST_WD_ABRT;
        end else begin
            wd_cnt_q   <= wd_cnt_d;
            wd_abort_q <= wd_abort_d;
        end
    end

    assign wd_abort_o = wd_abort_q;
`else
    logic wd_cycles_unused;
    assign wd_cycles_unused = WD_CYCLES[0];
    assign wd_fire          = 1'b0;
    assign wd_abort_o       = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        pkt_en_d   = pkt_en_q;
        rr_ptr_d   = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (any_req && out_ready_i) begin
                    state_d    = BUSY;
                    grant_d    = win_oh;
                    grant_id_d = win_idx;
                    pkt_en_d   = 1'b1;
                end
            end
            BUSY: begin
                // Head requests are deliberately ignored here: the worm owns the port.
                if ((flit_pass_i && tail_pass_i) || wd_fire) begin
                    state_d    = RELEASE;
                    grant_d    = '0;
                    grant_id_d = '0;
                    pkt_en_d   = 1'b0;
                    rr_ptr_d   = (grant_id_q == IW'(NUM_INPORTS - 1)) ? '0 : grant_id_q + 1'b1;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= RST_STATE;
            grant_q    <= '0;
            grant_id_q <= '0;
            pkt_en_q   <= RST_PKT_EN;
            busy_q     <= RST_BUSY;
            rr_ptr_q   <= IW'(RST_RR_PTR);
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            pkt_en_q   <= pkt_en_d;
            busy_q     <= busy_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    assign grant_o         = grant_q;
    assign grant_id_o      = grant_id_q;
    assign packet_enable_o = pkt_en_q;
    assign busy_o          = busy_q;
    assign dbg_state_o     = state_q;
    assign dbg_rr_ptr_o    = rr_ptr_q;

endmodule

// File: tb/tb_packet_output_arbiter.sv
// Bench for packet_output_arbiter: vector table, directed corner sequences, random vs packet-level model.
// Watchdog sequence runs only when PKT_ARB_WATCHDOG_EN is defined.
module tb_packet_output_arbiter;
    import mt_arb_pkg::*;

    localparam int N  = 4;
`ifdef PKT_ARB_WATCHDOG_EN
    localparam int WD = 8;
`else
    localparam int WD = 64;
`endif

    logic         clk;
    logic         rst_n;
    logic [N-1:0] head_req;
    logic         out_ready;
    logic         flit_pass;
    logic         tail_pass;
    logic [N-1:0] grant;
    logic [1:0]   grant_id;
    logic         packet_enable;
    logic         busy;
    logic         wd_abort;
    arb_state_e   dbg_state;
    logic [1:0]   dbg_rr_ptr;

    int n_pass  = 0;
    int n_total = 0;

    logic [1:0] exp_q[$];

    // Packet-level model: who owns the port, bubble cycles left, next-priority input.
    int m_owner;
    int m_cool;
    int m_rr;
    int m_idle;
    bit m_abort;

    typedef struct {
        logic [N-1:0] req;
        logic         rdy;
        logic         flit;
        logic         tail;
        logic [N-1:0] e_grant;
        logic [1:0]   e_id;
        logic         e_pen;
        logic         e_busy;
        logic [1:0]   e_rr;
    } vec_t;

    vec_t vecs[14];

    packet_output_arbiter #(.NUM_INPORTS(N), .WD_CYCLES(WD)) dut (
        .clk_i           (clk),
        .rst_n_i         (rst_n),
        .head_req_i      (head_req),
        .out_ready_i     (out_ready),
        .flit_pass_i     (flit_pass),
        .tail_pass_i     (tail_pass),
        .grant_o         (grant),
        .grant_id_o      (grant_id),
        .packet_enable_o (packet_enable),
        .busy_o          (busy),
        .wd_abort_o      (wd_abort),
        .dbg_state_o     (dbg_state),
        .dbg_rr_ptr_o    (dbg_rr_ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_cool  = 0;
        m_rr    = 0;
        m_idle  = 0;
        m_abort = 0;
    endtask

    task automatic model_step(input logic [N-1:0] req, input logic rdy, input logic flit, input logic tail);
        bit wd_hit;
        m_abort = 0;
        if (m_owner >= 0) begin
            wd_hit = 0;
`ifdef PKT_ARB_WATCHDOG_EN
            if (flit) m_idle = 0;
            else      m_idle++;
            wd_hit = (m_idle >= WD);
`endif
            if ((flit && tail) || wd_hit) begin
                m_abort = wd_hit;
                m_rr    = (m_owner + 1) % N;
                m_owner = -1;
                m_cool  = 1;
                m_idle  = 0;
            end
        end else if (m_cool > 0) begin
            m_cool = 0;
        end else if (req != 0 && rdy) begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && req[(m_rr + k) % N]) m_owner = (m_rr + k) % N;
            end
            m_idle = 0;
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".grant"}, grant, (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        check({tag, ".id"}, grant_id, (m_owner >= 0) ? m_owner : 0);
        check({tag, ".pen"}, packet_enable, m_owner >= 0);
        check({tag, ".busy"}, busy, (m_owner >= 0) || (m_cool > 0));
        check({tag, ".wd_abort"}, wd_abort, m_abort);
        check({tag, ".rr"}, dbg_rr_ptr, m_rr);
    endtask

    task automatic drive(input logic [N-1:0] req, input logic rdy, input logic flit, input logic tail);
        head_req  = req;
        out_ready = rdy;
        flit_pass = flit;
        tail_pass = tail;
    endtask

    task automatic cycle(input string tag, input logic [N-1:0] req, input logic rdy,
                         input logic flit, input logic tail);
        drive(req, rdy, flit, tail);
        @(posedge clk);
        model_step(req, rdy, flit, tail);
        #1;
        check_model(tag);
    endtask

    task automatic apply_reset();
        drive('0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        check("rst.grant", grant, 0);
        check("rst.id", grant_id, 0);
        check("rst.pen", packet_enable, 0);
        check("rst.busy", busy, 0);
        check("rst.wd_abort", wd_abort, 0);
        check("rst.rr", dbg_rr_ptr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        drive('0, 1'b0, 1'b0, 1'b0);

        //           req      rdy  f  t  grant    id pen busy rr
        vecs[0]  = '{4'b0100, 1, 0, 0, 4'b0100, 2, 1, 1, 0};
        vecs[1]  = '{4'b0000, 1, 1, 0, 4'b0100, 2, 1, 1, 0};
        vecs[2]  = '{4'b0010, 1, 1, 1, 4'b0000, 0, 0, 1, 3};
        vecs[3]  = '{4'b0011, 1, 0, 0, 4'b0000, 0, 0, 0, 3};
        vecs[4]  = '{4'b0011, 1, 0, 0, 4'b0001, 0, 1, 1, 3};
        vecs[5]  = '{4'b0000, 1, 0, 1, 4'b0001, 0, 1, 1, 3};
        vecs[6]  = '{4'b0000, 1, 1, 1, 4'b0000, 0, 0, 1, 1};
        vecs[7]  = '{4'b0000, 1, 1, 1, 4'b0000, 0, 0, 0, 1};
        vecs[8]  = '{4'b0000, 1, 1, 1, 4'b0000, 0, 0, 0, 1};
        vecs[9]  = '{4'b1001, 0, 0, 0, 4'b0000, 0, 0, 0, 1};
        vecs[10] = '{4'b1001, 1, 0, 0, 4'b1000, 3, 1, 1, 1};
        vecs[11] = '{4'b0000, 1, 1, 1, 4'b0000, 0, 0, 1, 0};
        vecs[12] = '{4'b0000, 1, 0, 0, 4'b0000, 0, 0, 0, 0};
        vecs[13] = '{4'b1111, 1, 0, 0, 4'b0001, 0, 1, 1, 0};

        apply_reset();
        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].req, vecs[i].rdy, vecs[i].flit, vecs[i].tail);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d.grant", i), grant, vecs[i].e_grant);
            check($sformatf("vec%0d.id", i), grant_id, vecs[i].e_id);
            check($sformatf("vec%0d.pen", i), packet_enable, vecs[i].e_pen);
            check($sformatf("vec%0d.busy", i), busy, vecs[i].e_busy);
            check($sformatf("vec%0d.rr", i), dbg_rr_ptr, vecs[i].e_rr);
        end

        // Round-robin rotation with all four requesting, single-flit packets.
        apply_reset();
        exp_q = {2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
        for (int p = 0; p < 5; p++) begin
            cycle("rr.grant", 4'b1111, 1, 0, 0);
            check("rr.order", grant_id, exp_q.pop_front());
            cycle("rr.tail", 4'b1111, 1, 1, 1);
            cycle("rr.bubble", 4'b1111, 1, 0, 0);
            check("rr.gap", grant, 0);
        end
        check("rr.queue_empty", exp_q.size(), 0);

        // Wormhole hold: owner drops its request, another input asks.
        apply_reset();
        cycle("wh.grant", 4'b0010, 1, 0, 0);
        for (int f = 0; f < 5; f++) begin
            cycle("wh.body", 4'b1000, 1, 1, 0);
            check("wh.hold", grant, 4'b0010);
        end
        cycle("wh.tail", 4'b1000, 1, 1, 1);
        check("wh.drop", grant, 0);
        cycle("wh.release", 4'b1000, 1, 0, 0);
        cycle("wh.next", 4'b1000, 1, 0, 0);
        check("wh.next_grant", grant, 4'b1000);

        // Downstream not ready holds off arbitration.
        apply_reset();
        for (int c = 0; c < 10; c++) cycle("nr.wait", 4'b0001, 0, 0, 0);
        check("nr.no_grant", grant, 0);
        cycle("nr.ready", 4'b0001, 1, 0, 0);
        check("nr.grant", grant, 4'b0001);

        // Asynchronous reset mid-packet clears outputs without a clock edge.
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst.grant", grant, 0);
        check("arst.pen", packet_enable, 0);
        check("arst.busy", busy, 0);

`ifdef PKT_ARB_WATCHDOG_EN
        apply_reset();
        cycle("wd.grant", 4'b0001, 1, 0, 0);
        for (int c = 0; c < WD - 1; c++) begin
            cycle("wd.idle", 4'b0000, 1, 0, 0);
            check("wd.no_abort", wd_abort, 0);
        end
        cycle("wd.fire", 4'b0000, 1, 0, 0);
        check("wd.abort", wd_abort, 1);
        check("wd.drop", grant, 0);
        check("wd.rr", dbg_rr_ptr, 1);
        cycle("wd.after", 4'b0000, 1, 0, 0);
        check("wd.one_pulse", wd_abort, 0);
`endif

        // Random traffic against the packet-level model.
        apply_reset();
        for (int c = 0; c < 400; c++) begin
            cycle("rnd", 4'($urandom_range(0, 15)), $urandom_range(0, 3) != 0,
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/packet_output_arbiter.md
# packet_output_arbiter

Clocked per-output-port wormhole arbiter for the MouseTrap router. It shares one output port between `NUM_INPORTS` input ports. It grants the port to one requester when that requester's head flit arrives, and holds the grant until the tail flit has passed. It drives the packet-enable level that gates the output request generator, and releases the grant on tail handoff using round-robin fairness.

## Interface
- `NUM_INPORTS`, 4, number of requesting input ports (≥2)
- `WD_CYCLES`, 64, watchdog idle limit in cycles; used only when the watchdog is compiled in (≥2)

- `clk_i`  in  1  clock
- `rst_n_i`  in  1  reset, asynchronous, active-low
- `head_req_i`  in  `NUM_INPORTS`  per-input request; high while that input holds a head flit routed to this port
- `out_ready_i`  in  1  downstream can accept a new packet
- `flit_pass_i`  in  1  one flit crossed the output port this cycle
- `tail_pass_i`  in  1  the flit passing this cycle is a tail; qualified by `flit_pass_i`
- `grant_o`  out  `NUM_INPORTS`  one-hot grant, registered
- `grant_id_o`  out  `$clog2(NUM_INPORTS)`  index of the granted input; 0 when idle
- `packet_enable_o`  out  1  high while a packet owns the port; feeds the request generator's packet-enable input
- `busy_o`  out  1  high in BUSY and RELEASE
- `wd_abort_o`  out  1  one-cycle pulse when the watchdog forces a release; tied 0 when the watchdog is compiled out

## Operation
- FSM states are IDLE, BUSY and RELEASE. Reset state is IDLE.
- Reset values: `grant_o`=0, `grant_id_o`=0, `packet_enable_o`=0, `busy_o`=0, `wd_abort_o`=0, `rr_ptr`=0.
- **IDLE:**
  - Transition: when `|head_req_i && out_ready_i`, pick a winner and go to BUSY.
  - Winner: the first set bit of `head_req_i` searching upward from `rr_ptr`, with modulo wrap.
  - On that edge, register `grant_o`, `grant_id_o` and `packet_enable_o`=1.
  - Otherwise stay in IDLE.
- **BUSY:**
  - The grant is held regardless of `head_req_i`, including when the winner deasserts its request (wormhole).
  - Transition: when `flit_pass_i && tail_pass_i`, go to RELEASE.
    - On that edge, clear `grant_o` and `packet_enable_o`.
    - On that edge, set `rr_ptr` to (winner+1) mod `NUM_INPORTS`.
  - `out_ready_i` is ignored in this state.
- **RELEASE:**
  - One-cycle bubble.
  - Unconditionally return to IDLE.
- **Input qualification:**
  - `tail_pass_i` without `flit_pass_i` is ignored.
  - `flit_pass_i` in IDLE or RELEASE is ignored.
- **Single-flit packet:** a head-and-tail flit passing in the first BUSY cycle releases normally.
- **Simultaneous requests:** exactly one grant is issued; the losers stay pending and are served in rotation.
- **`rr_ptr` wrap:** a winner of `NUM_INPORTS-1` sets `rr_ptr` to 0.
- **Reset mid-packet:** all outputs clear immediately (asynchronously); a partially sent packet is the upstream's responsibility.

## Timing
- Arbitration latency: `grant_o` and `packet_enable_o` are high 1 cycle after the edge on which `head_req_i && out_ready_i` is sampled in IDLE.
- Release latency: `grant_o` drops on the edge that samples the tail pass.
- Re-grant: the earliest next grant is 2 edges after the tail edge (RELEASE plus IDLE arbitration).
- Throughput: at most one packet per (packet length + 2) cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Configuration
- Macro: `PKT_ARB_WATCHDOG_EN`.
- **Defined:**
  - A counter of width `$clog2(WD_CYCLES+1)` increments in BUSY on each cycle without `flit_pass_i`.
  - The counter clears on any `flit_pass_i` and on leaving BUSY.
  - When the counter reaches `WD_CYCLES`, the FSM takes the RELEASE path as if a tail had passed.
  - `rr_ptr` advances as on a normal release, and `wd_abort_o` pulses for one cycle, aligned with the grant drop.
- **Undefined:**
  - No counter is present and `wd_abort_o` is constant 0.
  - BUSY persists indefinitely until a tail passes.

## Structure
- Package `mt_arb_pkg` contains:
  - the `arb_state_e` enum (IDLE, BUSY, RELEASE);
  - a `grant_idx_w` localparam function wrapping `$clog2`;
  - the reset constants.
- Sub-module `rr_picker`: purely combinational.
  - Inputs are the request vector and `rr_ptr`.
  - Outputs are the one-hot winner, the winner index and a `any_req` flag.
  - It is instantiated once.

## Test plan
- **Reset then single request:** release reset, drive `head_req_i`=4'b0100 with `out_ready_i`=1 → `grant_o`=4'b0100, `grant_id_o`=2 and `packet_enable_o`=1 one cycle later.
- **Round-robin rotation:** hold `head_req_i`=4'b1111 and send 1-flit packets back to back → grant order 0,1,2,3,0. Consecutive grants are separated by 2 idle cycles after each tail.
- **Wormhole hold:** grant input 1, deassert `head_req_i[1]`, assert `head_req_i[3]`, pass 5 non-tail flits → `grant_o` stays 4'b0010 until the tail edge.
- **Downstream not ready:** `head_req_i`=4'b0001 with `out_ready_i`=0 for 10 cycles → no grant. Raise `out_ready_i` → grant the next cycle.
- **Stray inputs:** in IDLE, pulse `flit_pass_i`=1 and `tail_pass_i`=1 → no state change and `rr_ptr` unchanged.
- **Watchdog (macro defined, `WD_CYCLES`=8):** grant input 0, then no flit passes → on the 8th idle BUSY cycle `wd_abort_o` pulses once, the grant drops and `rr_ptr`=1.
